// File: rtl/risk_pkg.sv
// Shared types and constants for the RISK tile-copy sequencer.
package risk_pkg;

  localparam int ADDR_W   = 17;
  localparam int STRIDE_W = 16;
  localparam int BLK_W    = 8;

  localparam logic [2:0] RISK_LOAD  = 3'b000;
  localparam logic [2:0] RISK_STORE = 3'b001;
  localparam logic [2:0] RISK_NOP   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ADDR,
    S_LD_FIRE,
    S_ST,
    S_ST_GAP,
    S_DONE
  } state_e;

  // Address offset of one 4x4 block along a stride: 4*stride, wrapped to the address width.
  function automatic logic [ADDR_W-1:0] blk_stride(input logic [STRIDE_W-1:0] s);
    logic [STRIDE_W+1:0] w;
    w = {s, 2'b00};
    return w[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/risk_tile_addr_gen.sv
// Incremental source/destination block address generator (row base + column pointer).
module risk_tile_addr_gen
  import risk_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                init,
  input  logic                step_x,
  input  logic                next_row,
  input  logic [ADDR_W-1:0]   src_base,
  input  logic [ADDR_W-1:0]   dst_base,
  input  logic [STRIDE_W-1:0] stride_x,
  input  logic [STRIDE_W-1:0] stride_y,
  input  logic [BLK_W-1:0]    bx,
  input  logic [BLK_W-1:0]    by,
  output logic [ADDR_W-1:0]   src_addr,
  output logic [ADDR_W-1:0]   dst_addr,
  output logic                row_end,
  output logic                last
);

  logic [ADDR_W-1:0] src_row_q, src_row_d, src_ptr_q, src_ptr_d;
  logic [ADDR_W-1:0] dst_row_q, dst_row_d, dst_ptr_q, dst_ptr_d;
  logic [BLK_W-1:0]  x_q, x_d, y_q, y_d, bx_q, bx_d, by_q, by_d;

  assign src_addr = src_ptr_q;
  assign dst_addr = dst_ptr_q;
  assign row_end  = (x_q == bx_q - 8'd1);
  assign last     = row_end && (y_q == by_q - 8'd1);

  // Next pointer values: load bases, advance one block in x, or start the next row.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    src_row_d = src_row_q;
    src_ptr_d = src_ptr_q;
    dst_row_d = dst_row_q;
    dst_ptr_d = dst_ptr_q;
    x_d       = x_q;
    y_d       = y_q;
    bx_d      = bx_q;
    by_d      = by_q;
    if (init) begin
      src_row_d = src_base;
      src_ptr_d = src_base;
      dst_row_d = dst_base;
      dst_ptr_d = dst_base;
      x_d       = '0;
      y_d       = '0;
      bx_d      = bx;
      by_d      = by;
    end else if (next_row) begin
      src_row_d = src_row_q + blk_stride(stride_y);
      src_ptr_d = src_row_q + blk_stride(stride_y);
      dst_row_d = dst_row_q + blk_stride(stride_y);
      dst_ptr_d = dst_row_q + blk_stride(stride_y);
      x_d       = '0;
      y_d       = y_q + 8'd1;
    end else if (step_x) begin
      src_ptr_d = src_ptr_q + blk_stride(stride_x);
      dst_ptr_d = dst_ptr_q + blk_stride(stride_x);
      x_d       = x_q + 8'd1;
    end
  end

  // Pointer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, avoiding simulation races.
    if (!resetn) begin
      src_row_q <= '0;
      src_ptr_q <= '0;
      dst_row_q <= '0;
      dst_ptr_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      bx_q      <= '0;
      by_q      <= '0;
    end else begin
      src_row_q <= src_row_d;
      src_ptr_q <= src_ptr_d;
      dst_row_q <= dst_row_d;
      dst_ptr_q <= dst_ptr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
    end
  end

endmodule

// File: rtl/risk_tile_seq.sv
// Tile-copy command initiator: LOADs each 4x4 block into a staging register and STOREs it out.
module risk_tile_seq
  import risk_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 2,
  parameter logic [4:0]  REG      = 5'd0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [STRIDE_W-1:0] cmd_stride_x,
  input  logic [STRIDE_W-1:0] cmd_stride_y,
  input  logic [BLK_W-1:0]    cmd_bx,
  input  logic [BLK_W-1:0]    cmd_by,
  input  logic                abort,
  output logic [2:0]          risk_func,
  output logic [4:0]          risk_reg,
  output logic [ADDR_W-1:0]   risk_addr,
  output logic [STRIDE_W-1:0] risk_stride_x,
  output logic [STRIDE_W-1:0] risk_stride_y,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [15:0]         blocks_done
);

  localparam logic [7:0] LAT_LAST = 8'(LOAD_LAT - 1);

  state_e             state_q, state_d;
  logic [7:0]         lat_cnt_q, lat_cnt_d;
  logic [2:0]         func_q, func_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [STRIDE_W-1:0] sx_q, sx_d, sy_q, sy_d;
  logic               done_q, done_d, aborted_q, aborted_d;
  logic               abort_flag_q, abort_flag_d, last_q, last_d;
  logic [15:0]        blocks_done_q, blocks_done_d;

  logic               gen_init, gen_step_x, gen_next_row;
  logic [ADDR_W-1:0]  gen_src, gen_dst;
  logic               gen_row_end, gen_last;

  assign cmd_ready     = (state_q == S_IDLE) && resetn;
  assign risk_func     = func_q;
  assign risk_reg      = REG;
  assign risk_addr     = addr_q;
  assign risk_stride_x = sx_q;
  assign risk_stride_y = sy_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign blocks_done   = blocks_done_q;

  risk_tile_addr_gen u_addr_gen (
    .clk      (clk),
    .resetn   (resetn),
    .init     (gen_init),
    .step_x   (gen_step_x),
    .next_row (gen_next_row),
    .src_base (cmd_src),
    .dst_base (cmd_dst),
    .stride_x (sx_q),
    .stride_y (sy_q),
    .bx       (cmd_bx),
    .by       (cmd_by),
    .src_addr (gen_src),
    .dst_addr (gen_dst),
    .row_end  (gen_row_end),
    .last     (gen_last)
  );

  // Next state and next registered outputs; outputs are set on entry to each state.
  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    func_d        = func_q;
    addr_d        = addr_q;
    sx_d          = sx_q;
    sy_d          = sy_q;
    done_d        = 1'b0;
    aborted_d     = aborted_q;
    abort_flag_d  = abort_flag_q;
    last_d        = last_q;
    blocks_done_d = blocks_done_q;
    gen_init      = 1'b0;
    gen_step_x    = 1'b0;
    gen_next_row  = 1'b0;

    if (abort && state_q != S_IDLE && state_q != S_DONE) abort_flag_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        func_d = RISK_NOP;
        if (cmd_valid) begin
          sx_d          = cmd_stride_x;
          sy_d          = cmd_stride_y;
          blocks_done_d = '0;
          abort_flag_d  = 1'b0;
          aborted_d     = 1'b0;
          if (cmd_bx == '0 || cmd_by == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = S_LD_ADDR;
            lat_cnt_d = '0;
            addr_d    = cmd_src;
            gen_init  = 1'b1;
          end
        end
      end
      S_LD_ADDR: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d = S_LD_FIRE;
          func_d  = RISK_LOAD;
        end else begin
          lat_cnt_d = lat_cnt_q + 8'd1;
        end
      end
      S_LD_FIRE: begin
        state_d = S_ST;
        func_d  = RISK_STORE;
        addr_d  = gen_dst;
      end
      S_ST: begin
        // The block's addresses are consumed; advance the generator during the gap cycle.
        state_d      = S_ST_GAP;
        func_d       = RISK_NOP;
        last_d       = gen_last;
        gen_next_row = !gen_last && gen_row_end;
        gen_step_x   = !gen_last && !gen_row_end;
      end
      S_ST_GAP: begin
        blocks_done_d = blocks_done_q + 16'd1;
        if (last_q || abort_flag_q || abort) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          aborted_d = abort_flag_q || abort;
        end else begin
          state_d   = S_LD_ADDR;
          lat_cnt_d = '0;
          addr_d    = gen_src;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      lat_cnt_q     <= '0;
      func_q        <= RISK_NOP;
      addr_q        <= '0;
      sx_q          <= '0;
      sy_q          <= '0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      abort_flag_q  <= 1'b0;
      last_q        <= 1'b0;
      blocks_done_q <= '0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      func_q        <= func_d;
      addr_q        <= addr_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      abort_flag_q  <= abort_flag_d;
      last_q        <= last_d;
      blocks_done_q <= blocks_done_d;
    end
  end

endmodule

// File: tb/tb_risk_tile_seq.sv
// Self-checking bench for risk_tile_seq: directed table, random commands, reset corner case.
module tb_risk_tile_seq;
  import risk_pkg::*;

  localparam int LL = 2;
  localparam int P  = LL + 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [16:0] cmd_src, cmd_dst;
  logic [15:0] cmd_stride_x, cmd_stride_y;
  logic [7:0]  cmd_bx, cmd_by;
  logic        abort;
  logic [2:0]  risk_func;
  logic [4:0]  risk_reg;
  logic [16:0] risk_addr;
  logic [15:0] risk_stride_x, risk_stride_y;
  logic        busy, done, aborted;
  logic [15:0] blocks_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  risk_tile_seq #(.LOAD_LAT(LL), .REG(5'd0)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_stride_x(cmd_stride_x),
    .cmd_stride_y(cmd_stride_y), .cmd_bx(cmd_bx), .cmd_by(cmd_by), .abort(abort),
    .risk_func(risk_func), .risk_reg(risk_reg), .risk_addr(risk_addr),
    .risk_stride_x(risk_stride_x), .risk_stride_y(risk_stride_y), .busy(busy),
    .done(done), .aborted(aborted), .blocks_done(blocks_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference address of block (i,j): plain arithmetic, wrapped to 17 bits.
  function automatic logic [16:0] blk_addr(input logic [16:0] base, input int i, input int j,
                                           input logic [15:0] sx, input logic [15:0] sy);
    int unsigned a;
    a = 32'(base) + 4 * i * 32'(sx) + 4 * j * 32'(sy);
    return a[16:0];
  endfunction

  // Issue one command and compare every cycle against the timing model until back in IDLE.
  task automatic run_cmd(input logic [16:0] src, input logic [16:0] dst,
                         input logic [15:0] sx, input logic [15:0] sy,
                         input logic [7:0] bx, input logic [7:0] by, input int ab_c,
                         output int done_seen, output int nloads,
                         output logic [16:0] last_ld, output logic [16:0] last_st,
                         output logic ab_seen, output logic [15:0] bd_seen);
    int n, n_eff, done_c, k, ph, bi, bj;
    logic exp_ab;
    logic [2:0]  ef;
    logic [16:0] ea;
    logic [63:0] sig_a, sig_e;
    n = int'(bx) * int'(by);
    exp_ab = (n > 0) && (ab_c >= 1) && (ab_c <= P * n);
    n_eff  = (n == 0) ? 0 : (exp_ab ? (ab_c - 1) / P + 1 : n);
    done_c = P * n_eff + 1;
    done_seen = 0; nloads = 0; last_ld = '0; last_st = '0; ab_seen = 1'b0; bd_seen = '0;

    @(negedge clk);
    check("ready_before_cmd", 64'(cmd_ready), 64'd1);
    cmd_src = src; cmd_dst = dst; cmd_stride_x = sx; cmd_stride_y = sy;
    cmd_bx = bx; cmd_by = by; cmd_valid = 1'b1;

    for (int c = 1; c <= done_c + 1; c++) begin
      @(negedge clk);
      // Keep a junk descriptor offered while busy: it must never be taken.
      cmd_valid = (c < done_c);
      if (c == 1) begin
        cmd_src = 17'($urandom); cmd_dst = 17'($urandom);
        cmd_bx = 8'($urandom_range(1, 3)); cmd_by = 8'($urandom_range(1, 3));
      end
      abort = (c == ab_c);
      if (c < done_c) begin
        k  = (c - 1) / P;
        ph = (c - 1) % P;
        bi = k % int'(bx);
        bj = k / int'(bx);
        if (ph < LL)       begin ef = RISK_NOP;   ea = blk_addr(src, bi, bj, sx, sy); end
        else if (ph == LL) begin ef = RISK_LOAD;  ea = blk_addr(src, bi, bj, sx, sy); end
        else if (ph == LL + 1) begin ef = RISK_STORE; ea = blk_addr(dst, bi, bj, sx, sy); end
        else               begin ef = RISK_NOP;   ea = blk_addr(dst, bi, bj, sx, sy); end
        sig_a = {risk_func, risk_reg, risk_addr, busy, done, blocks_done, risk_stride_x};
        sig_e = {ef, 5'd0, ea, 1'b1, 1'b0, 16'(k), sx};
        check($sformatf("cycle%0d_func_addr_state", c), sig_a, sig_e);
      end else if (c == done_c) begin
        sig_a = {risk_func, busy, done, aborted, blocks_done, risk_stride_y};
        sig_e = {RISK_NOP, 1'b1, 1'b1, exp_ab, 16'(n_eff), sy};
        check($sformatf("done_cycle%0d", c), sig_a, sig_e);
      end else begin
        sig_a = {risk_func, busy, done, cmd_ready, blocks_done};
        sig_e = {RISK_NOP, 1'b0, 1'b0, 1'b1, 16'(n_eff)};
        check("idle_after_done", sig_a, sig_e);
      end
      if (risk_func == RISK_LOAD) begin nloads++; last_ld = risk_addr; end
      if (risk_func == RISK_STORE) last_st = risk_addr;
      if (done) begin done_seen = c; ab_seen = aborted; bd_seen = blocks_done; end
    end
    abort = 1'b0;
  endtask

  typedef struct {
    logic [16:0] src, dst;
    logic [15:0] sx, sy;
    logic [7:0]  bx, by;
    int          ab_c;
    int          exp_done;
    int          exp_nloads;
    logic [15:0] exp_bd;
    logic        exp_ab;
    logic [16:0] exp_last_ld, exp_last_st;
  } vec_t;

  initial begin
    vec_t vecs[5];
    int done_seen, nloads, n, ab;
    logic [16:0] last_ld, last_st, rs, rd;
    logic ab_seen;
    logic [15:0] bd_seen, rsx, rsy;
    logic [7:0] rbx, rby;

    vecs[0] = '{17'h00100, 17'h00200, 16'd1, 16'd16, 8'd1, 8'd1, 0, 6,  1, 16'd1, 1'b0, 17'h00100, 17'h00200};
    vecs[1] = '{17'h00000, 17'h00400, 16'd1, 16'd32, 8'd2, 8'd2, 0, 21, 4, 16'd4, 1'b0, 17'h00084, 17'h00484};
    vecs[2] = '{17'h1FFFE, 17'h00300, 16'd1, 16'd4,  8'd2, 8'd1, 0, 11, 2, 16'd2, 1'b0, 17'h00002, 17'h00304};
    vecs[3] = '{17'h00123, 17'h00456, 16'd1, 16'd1,  8'd0, 8'd5, 0, 1,  0, 16'd0, 1'b0, 17'h00000, 17'h00000};
    vecs[4] = '{17'h00000, 17'h00400, 16'd1, 16'd32, 8'd2, 8'd2, 4, 6,  1, 16'd1, 1'b1, 17'h00000, 17'h00400};

    resetn = 1'b0; cmd_valid = 1'b0; abort = 1'b0;
    cmd_src = '0; cmd_dst = '0; cmd_stride_x = '0; cmd_stride_y = '0; cmd_bx = '0; cmd_by = '0;
    repeat (3) @(negedge clk);
    check("reset_values",
          {risk_func, risk_reg, risk_addr, risk_stride_x, risk_stride_y, busy, done, aborted, blocks_done},
          {RISK_NOP, 5'd0, 17'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0});
    resetn = 1'b1;

    // Directed vectors from the table.
    for (int v = 0; v < 5; v++) begin
      run_cmd(vecs[v].src, vecs[v].dst, vecs[v].sx, vecs[v].sy, vecs[v].bx, vecs[v].by,
              vecs[v].ab_c, done_seen, nloads, last_ld, last_st, ab_seen, bd_seen);
      check($sformatf("vec%0d_done_cycle", v), 64'(done_seen), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d_loads", v), 64'(nloads), 64'(vecs[v].exp_nloads));
      check($sformatf("vec%0d_blocks_aborted", v), {bd_seen, ab_seen}, {vecs[v].exp_bd, vecs[v].exp_ab});
      if (vecs[v].exp_nloads > 0)
        check($sformatf("vec%0d_last_ld_st", v), {last_ld, last_st}, {vecs[v].exp_last_ld, vecs[v].exp_last_st});
    end

    // Random commands, half with an abort kept off the gap cycle.
    for (int r = 0; r < 25; r++) begin
      rs = 17'($urandom); rd = 17'($urandom);
      rsx = 16'($urandom); rsy = 16'($urandom);
      rbx = 8'($urandom_range(0, 3)); rby = 8'($urandom_range(0, 3));
      n = int'(rbx) * int'(rby);
      ab = 0;
      if ($urandom_range(0, 1) == 1) begin
        ab = $urandom_range(1, P * n + 2);
        if (ab <= P * n && (ab - 1) % P == P - 1) ab = ab - 1;
      end
      run_cmd(rs, rd, rsx, rsy, rbx, rby, ab, done_seen, nloads, last_ld, last_st, ab_seen, bd_seen);
    end

    // Reset during the LOAD cycle, with cmd_valid held through reset.
    @(negedge clk);
    cmd_src = 17'h00100; cmd_dst = 17'h00200; cmd_stride_x = 16'd1; cmd_stride_y = 16'd16;
    cmd_bx = 8'd1; cmd_by = 8'd1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_seq_load_cycle3", {risk_func, risk_addr}, {RISK_LOAD, 17'h00100});
    resetn = 1'b0;
    cmd_src = 17'h00AB0; cmd_dst = 17'h00CD0; cmd_valid = 1'b1;
    for (int c = 4; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("rst_seq_cycle%0d_reset_state", c),
            {risk_func, busy, done, cmd_ready, risk_addr, blocks_done},
            {RISK_NOP, 1'b0, 1'b0, 1'b0, 17'd0, 16'd0});
    end
    resetn = 1'b1;
    #1;
    check("rst_seq_ready_after_release", 64'(cmd_ready), 64'd1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (c == 1) check("rst_seq_accepted", {busy, risk_func, risk_addr}, {1'b1, RISK_NOP, 17'h00AB0});
      if (c == 3) check("rst_seq_new_load", {risk_func, risk_addr}, {RISK_LOAD, 17'h00AB0});
      if (c == 4) check("rst_seq_new_store", {risk_func, risk_addr}, {RISK_STORE, 17'h00CD0});
      if (c == 6) check("rst_seq_new_done", {done, aborted, blocks_done}, {1'b1, 1'b0, 16'd1});
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/risk_tile_seq.md
Name: risk_tile_seq

Overview:
Command initiator for the RISK strided 4x4 load/store unit. It accepts one tile-copy descriptor (source base, destination base, strides, tile size in 4x4 blocks). It then drives risk_func/risk_reg/risk_addr/risk_stride_x/risk_stride_y cycle by cycle, so that each block is LOADed into a RISK register and STOREd to the destination. It sits between the core's command issue logic and the risk unit, and owns all load-latency and write-hazard timing.

Parameters:
LOAD_LAT, 2, cycles risk_addr must be held stable before func=LOAD (address register + read register).
REG, 0, RISK register index used as the staging buffer.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  = (state==IDLE) && resetn
cmd_src  in  17  source base address
cmd_dst  in  17  destination base address
cmd_stride_x  in  16  element stride in x (used for both src and dst)
cmd_stride_y  in  16  element stride in y
cmd_bx  in  8  blocks in x; 0 = empty tile
cmd_by  in  8  blocks in y; 0 = empty tile
abort  in  1  request early termination
risk_func  out  3  LOAD=000, STORE=001, NOP=111
risk_reg  out  5  always REG
risk_addr  out  17  block base address
risk_stride_x  out  16  latched cmd_stride_x
risk_stride_y  out  16  latched cmd_stride_y
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
aborted  out  1  valid with done: command terminated by abort
blocks_done  out  16  blocks fully stored in current/last command

Behaviour:
- Clock and reset are fixed: one clock clk; reset resetn is synchronous and active-low.
- Reset values: risk_func=NOP, risk_reg=REG, risk_addr=0, strides=0, busy=0, done=0, aborted=0, blocks_done=0, state IDLE.
- Accept a command on the clk edge with cmd_valid && cmd_ready. At acceptance, latch all descriptor fields, clear blocks_done, and clear the abort flag. Cycle 1 is the first cycle after acceptance.
- FSM states: IDLE, LD_ADDR, LD_FIRE, ST, ST_GAP, DONE.
- IDLE: func=NOP. Accepting a command with bx==0 or by==0 goes to DONE. Any other accepted command goes to LD_ADDR with lat_cnt=0.
- LD_ADDR: risk_addr = src block address, func=NOP. Hold for LOAD_LAT cycles, then go to LD_FIRE.
- LD_FIRE: one cycle, func=LOAD, risk_addr held unchanged.
- ST: one cycle, risk_addr = dst block address, func=STORE.
- ST_GAP: one cycle, func=NOP, risk_addr held. This cycle prevents the next block's read from overlapping the pending write. At the end of this cycle blocks_done increments. The next state is DONE if this was the last block or the abort flag is set; otherwise LD_ADDR for the next block.
- DONE: one cycle, done=1, func=NOP. aborted = abort flag. Next state IDLE.
- Block period P = LOAD_LAT+3. Block k (0-based, row-major, x inner) fires LOAD in cycle P*k+LOAD_LAT+1 and STORE one cycle later. done is asserted in cycle P*bx*by+1.
- Address arithmetic, block (i,j) with i = x block index, j = y block index: base + 4*i*stride_x + 4*j*stride_y, computed incrementally. Strides are zero-extended to 17 bits and all sums wrap mod 2^17. Multiplies are not allowed.
- abort: sampled every cycle while busy and sets a sticky flag; ignored in IDLE and DONE. Abort is honoured only at the end of ST_GAP, so a LOAD is never left without its STORE.
- cmd_valid while busy is ignored (not accepted).
- Reset mid-operation: the next cycle shows reset values. No STORE is issued after reset, even if a LOAD already fired.

Decomposition:
- Package risk_pkg: func codes RISK_LOAD/RISK_STORE/RISK_NOP, ADDR_W=17, STRIDE_W=16, BLK_W=8, state enum.
- Sub-module risk_tile_addr_gen: holds the row base and column pointer for src and dst. Its inputs are init/step_x/next_row; its outputs are the current src and dst addresses and last flag.

Test Plan:
- src=0x100, dst=0x200, sx=1, sy=16, bx=by=1 -> addr 0x100/NOP cycles 1-2; LOAD@0x100 cycle 3; STORE@0x200 cycle 4; NOP cycle 5; done cycle 6; cmd_ready=1 cycle 7; blocks_done=1.
- src=0, dst=0x400, sx=1, sy=32, bx=by=2 -> LOAD addrs 0x000,0x004,0x080,0x084 at cycles 3,8,13,18; STOREs 0x400,0x404,0x480,0x484 at cycles 4,9,14,19; done cycle 21.
- src=0x1FFFE, sx=1, sy=4, bx=2, by=1 -> second LOAD addr 0x00002 (wrap mod 2^17).
- bx=0, by=5 -> done=1 cycle 1, aborted=0, blocks_done=0, no LOAD/STORE ever.
- 2x2 command, abort pulsed cycle 4 -> STORE block 0 cycle 4; done cycle 6 with aborted=1, blocks_done=1; no further LOAD.
- resetn low in cycle 3 (LOAD cycle) -> cycle 4 func=NOP, busy=0, done=0. cmd_valid held high during reset is not accepted; accepted on the first cycle with resetn high.
